// File: rtl/gs232c_bht_pkg.sv
// rtl/gs232c_bht_pkg.sv - Shared types, hash and counter helpers for the gs232c BHT.
package gs232c_bht_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    function automatic logic [31:0] low_mask(input int w);
        return (32'h1 << w) - 32'h1;
    endfunction

    // Slices beyond the real history width are zero, which pads the last slice.
    function automatic logic [31:0] fold_ghr(input logic [63:0] ghr, input int idx_w);
        logic [31:0] r;
        r = '0;
        for (int s = 0; s < 64; s += idx_w) begin
            r ^= 32'(ghr >> s) & low_mask(idx_w);
        end
        return r;
    endfunction

    function automatic logic [31:0] idx_hash(input logic [31:0] pc, input logic [63:0] ghr,
                                             input int lb, input int idx_w);
        return ((pc >> (2 + lb)) ^ fold_ghr(ghr, idx_w)) & low_mask(idx_w);
    endfunction

    function automatic logic [31:0] tag_hash(input logic [31:0] pc, input logic [63:0] ghr,
                                             input int lb, input int idx_w, input int tag_w);
        return ((pc >> (2 + lb + idx_w)) ^ 32'(ghr)) & low_mask(tag_w);
    endfunction

    function automatic logic [7:0] cnt_wnt(input int cnt_w);
        return 8'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic logic [7:0] cnt_wt(input int cnt_w);
        return 8'(1 << (cnt_w - 1));
    endfunction

    function automatic logic [7:0] sat_update(input logic [7:0] cnt, input logic taken,
                                              input int cnt_w);
        logic [7:0] mx;
        mx = 8'((1 << cnt_w) - 1);
        if (taken) begin
            return (cnt == mx) ? cnt : cnt + 8'd1;
        end
        return (cnt == 8'd0) ? cnt : cnt - 8'd1;
    endfunction

endpackage

// File: rtl/gs232c_bht_fifo.sv
// rtl/gs232c_bht_fifo.sv - Parametrised FIFO with flush; push and pop may coincide when full.
module gs232c_bht_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/gs232c_bht_v2.sv
// rtl/gs232c_bht_v2.sv - Tagged per-lane BHT with init sweep, output buffer and RMW training.
// Define GS232C_BHT_FWD_EN so a same-cycle lookup sees the lane being written by U1.
module gs232c_bht_v2
    import gs232c_bht_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int IDX_W     = 8,
    parameter int CNT_W     = 2,
    parameter int TAG_W     = 8,
    parameter int GHR_W     = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [31:0]      pred_pc,
    input  logic [GHR_W-1:0] pred_ghr,
    input  logic             pred_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_hint,
    output logic [LANES-1:0] out_taken,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    output logic             init_busy
);

    localparam int LB      = $clog2(LANES);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] WNT_C = CNT_W'(cnt_wnt(CNT_W));
    localparam logic [CNT_W-1:0] WT_C  = CNT_W'(cnt_wt(CNT_W));

    bht_state_e       r_state;
    bht_state_e       w_state_nxt;
    logic             w_init_busy;
    logic [IDX_W-1:0] r_init_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_init_busy = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_busy = 1'b1;
                if (r_init_idx == {IDX_W{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_idx <= r_init_idx + 1'b1;
            end
        end
    end

    assign init_busy = w_init_busy;
    assign upd_ready = (r_state == ST_RUN);

    logic [IDX_W-1:0] w_p_idx;
    logic [TAG_W-1:0] w_p_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic [LB-1:0]    w_u_lane;

    assign w_p_idx  = IDX_W'(idx_hash(pred_pc, 64'(pred_ghr), LB, IDX_W));
    assign w_p_tag  = TAG_W'(tag_hash(pred_pc, 64'(pred_ghr), LB, IDX_W, TAG_W));
    assign w_u_idx  = IDX_W'(idx_hash(upd_pc, 64'(upd_ghr), LB, IDX_W));
    assign w_u_tag  = TAG_W'(tag_hash(upd_pc, 64'(upd_ghr), LB, IDX_W, TAG_W));
    assign w_u_lane = upd_pc[LB+1:2];

    // U1 holds one accepted training request; its read-modify-write lands at the next edge.
    logic             r_u1_vld;
    logic [IDX_W-1:0] r_u1_idx;
    logic [LB-1:0]    r_u1_lane;
    logic [TAG_W-1:0] r_u1_tag;
    logic             r_u1_taken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_u1_vld   <= 1'b0;
            r_u1_idx   <= '0;
            r_u1_lane  <= '0;
            r_u1_tag   <= '0;
            r_u1_taken <= 1'b0;
        end else begin
            r_u1_vld <= upd_valid && upd_ready;
            if (upd_valid && upd_ready) begin
                r_u1_idx   <= w_u_idx;
                r_u1_lane  <= w_u_lane;
                r_u1_tag   <= w_u_tag;
                r_u1_taken <= upd_taken;
            end
        end
    end

    logic [LANES-1:0]            w_u_vld_all;
    logic [LANES-1:0][TAG_W-1:0] w_u_tag_all;
    logic [LANES-1:0][CNT_W-1:0] w_u_cnt_all;
    logic                        w_u_hit;
    logic [CNT_W-1:0]            w_u_new_cnt;
    logic [LANES-1:0]            w_hint;
    logic [LANES-1:0]            w_taken;

    assign w_u_hit     = w_u_vld_all[r_u1_lane] && (w_u_tag_all[r_u1_lane] == r_u1_tag);
    assign w_u_new_cnt = w_u_hit ? CNT_W'(sat_update(8'(w_u_cnt_all[r_u1_lane]), r_u1_taken, CNT_W))
                                 : (r_u1_taken ? WT_C : WNT_C);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic             r_vld [ENTRIES];
        logic [TAG_W-1:0] r_tag [ENTRIES];
        logic [CNT_W-1:0] r_cnt [ENTRIES];
        logic             w_sel;
        logic             w_vld;
        logic [TAG_W-1:0] w_tag;
        logic [CNT_W-1:0] w_cnt;

        assign w_sel = r_u1_vld && (r_u1_lane == LB'(g));

        always_ff @(posedge clock) begin
            if (r_state == ST_INIT) begin
                r_vld[r_init_idx] <= 1'b0;
                r_tag[r_init_idx] <= '0;
                r_cnt[r_init_idx] <= WNT_C;
            end else if (w_sel) begin
                r_vld[r_u1_idx] <= 1'b1;
                r_tag[r_u1_idx] <= r_u1_tag;
                r_cnt[r_u1_idx] <= w_u_new_cnt;
            end
        end

        assign w_u_vld_all[g] = r_vld[r_u1_idx];
        assign w_u_tag_all[g] = r_tag[r_u1_idx];
        assign w_u_cnt_all[g] = r_cnt[r_u1_idx];

        always_comb begin
            w_vld = r_vld[w_p_idx];
            w_tag = r_tag[w_p_idx];
            w_cnt = r_cnt[w_p_idx];
`ifdef GS232C_BHT_FWD_EN
            if (w_sel && (r_u1_idx == w_p_idx)) begin
                w_vld = 1'b1;
                w_tag = r_u1_tag;
                w_cnt = w_u_new_cnt;
            end
`endif
        end

        assign w_hint[g]  = w_vld && (w_tag == w_p_tag);
        assign w_taken[g] = w_hint[g] && w_cnt[CNT_W-1];
    end

    logic [CW-1:0]        w_count;
    logic [2*LANES-1:0]   w_buf_data;
    logic                 w_push;

    assign pred_ready = (r_state == ST_RUN) && !pred_flush &&
                        ((w_count < CW'(BUF_DEPTH)) || (out_valid && out_ready));
    assign w_push     = pred_valid && pred_ready;

    gs232c_bht_fifo #(
        .WIDTH (2 * LANES),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_out_buf (
        .clock   (clock),
        .reset   (reset),
        .i_flush (pred_flush),
        .i_push  (w_push),
        .i_data  ({w_hint, w_taken}),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  (w_buf_data),
        .o_count (w_count)
    );

    assign out_hint  = w_buf_data[2*LANES-1:LANES];
    assign out_taken = w_buf_data[LANES-1:0];

endmodule
